probe_issue_unit: RTL and testbench

//  Manager-side (L2) originator of TileLink coherence probes. Takes one probe

---
 rtl/probe_issue_unit_pkg.sv | 52 +++++
 rtl/probe_issue_unit_if.sv | 54 +++++
 rtl/probe_issue_unit_lowest_one_pick.sv | 20 ++
 rtl/probe_issue_unit.sv | 126 ++++++++++++
 tb/tb_probe_issue_unit.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/probe_issue_unit_pkg.sv
// probe_issue_unit_pkg: TileLink probe encodings, sizing constants and probe-issue types
// Shared by the probe issue unit, its bus interface and its sub-module.
//   - sizing: client count, address/data widths, beats per block
//   - channel B/C opcodes, B cap params, C report params
//   - FSM state enum and the latched request struct
package probe_issue_unit_pkg;
    localparam int N_CLIENTS = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int BEATS = 8;
    localparam int SRC_W = N_CLIENTS > 1 ? $clog2(N_CLIENTS) : 1;
    localparam int BEAT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [3:0] BLOCK_LG_SIZE = 4'd6;

    typedef enum logic [2:0] {
        OP_PROBE_ACK = 3'd4,
        OP_PROBE_ACK_DATA = 3'd5,
        OP_PROBE = 3'd6
    } tl_opcode_e;

    typedef enum logic [1:0] {
        CAP_TO_T = 2'd0,
        CAP_TO_B = 2'd1,
        CAP_TO_N = 2'd2
    } cap_param_e;

    typedef enum logic [2:0] {
        RPT_T_TO_B = 3'd0,
        RPT_T_TO_N = 3'd1,
        RPT_B_TO_N = 3'd2,
        RPT_T_TO_T = 3'd3,
        RPT_B_TO_B = 3'd4,
        RPT_N_TO_N = 3'd5
    } report_param_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_COLLECT,
        S_RESP
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0] param;
    } probe_req_t;

    // True when the client reports it held Trunk before the probe.
    function automatic logic reports_t(input logic [2:0] p);
        return p == RPT_T_TO_B || p == RPT_T_TO_N || p == RPT_T_TO_T;
    endfunction
endpackage

// File: rtl/probe_issue_unit_if.sv
// probe_issue_unit_if: request, channel B, channel C, writeback and status signals
// of the probe issue unit.
//   master : the surrounding L2 logic / clients (drives req, b_ready, C, wb_ready)
//   slave  : the probe issue unit itself
interface probe_issue_unit_if;
    import probe_issue_unit_pkg::*;
    logic io_req_valid;
    logic io_req_ready;
    logic [ADDR_W-1:0] io_req_addr;
    logic [1:0] io_req_param;
    logic [N_CLIENTS-1:0] io_req_mask;
    logic io_b_valid;
    logic io_b_ready;
    logic [2:0] io_b_opcode;
    logic [1:0] io_b_param;
    logic [SRC_W-1:0] io_b_source;
    logic [ADDR_W-1:0] io_b_address;
    logic [3:0] io_b_size;
    logic io_c_valid;
    logic io_c_ready;
    logic [2:0] io_c_opcode;
    logic [2:0] io_c_param;
    logic [SRC_W-1:0] io_c_source;
    logic [ADDR_W-1:0] io_c_address;
    logic [DATA_W-1:0] io_c_data;
    logic io_wb_valid;
    logic io_wb_ready;
    logic [DATA_W-1:0] io_wb_data;
    logic [BEAT_W-1:0] io_wb_beat;
    logic io_wb_last;
    logic io_resp_valid;
    logic io_resp_dirty;
    logic io_resp_had_t;
    logic io_err;
    logic io_busy;

    modport master (
        output io_req_valid, io_req_addr, io_req_param, io_req_mask, io_b_ready,
               io_c_valid, io_c_opcode, io_c_param, io_c_source, io_c_address, io_c_data,
               io_wb_ready,
        input  io_req_ready, io_b_valid, io_b_opcode, io_b_param, io_b_source, io_b_address,
               io_b_size, io_c_ready, io_wb_valid, io_wb_data, io_wb_beat, io_wb_last,
               io_resp_valid, io_resp_dirty, io_resp_had_t, io_err, io_busy
    );

    modport slave (
        input  io_req_valid, io_req_addr, io_req_param, io_req_mask, io_b_ready,
               io_c_valid, io_c_opcode, io_c_param, io_c_source, io_c_address, io_c_data,
               io_wb_ready,
        output io_req_ready, io_b_valid, io_b_opcode, io_b_param, io_b_source, io_b_address,
               io_b_size, io_c_ready, io_wb_valid, io_wb_data, io_wb_beat, io_wb_last,
               io_resp_valid, io_resp_dirty, io_resp_had_t, io_err, io_busy
    );
endinterface

// File: rtl/probe_issue_unit_lowest_one_pick.sv
// lowest_one_pick: one-hot mask and binary index of the lowest set bit of vec
//   vec    in  N  candidate vector
//   onehot out N  lowest set bit isolated (0 when vec is 0)
//   idx    out W  index of that bit (0 when vec is 0)
module lowest_one_pick #(
    parameter int N = 2,
    parameter int W = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0] vec,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx
);
    always_comb begin
        onehot = vec & (~vec + 1'b1);
        idx = '0;
        // Scan downward so the lowest set bit is written last and wins.
        for (int i = N - 1; i >= 0; i--)
            if (vec[i]) idx = W'(i);
    end
endmodule

// File: rtl/probe_issue_unit.sv
// probe_issue_unit: L2-side issuer of TileLink Probes and collector of ProbeAck/ProbeAckData
//   clock  in  single clock
//   reset  in  asynchronous, active-low
//   bus    slave modport of probe_issue_unit_if:
//          req   probe request (addr, cap param, client mask), ready only when idle
//          b     one Probe per masked client, lowest client index first
//          c     ProbeAck / ProbeAckData from clients
//          wb    dirty data beats passed through to the writeback buffer
//          resp  one-cycle completion pulse with dirty / had_t flags
//          err   sticky protocol error, busy = not idle
module probe_issue_unit
    import probe_issue_unit_pkg::*;
(
    input logic clock,
    input logic reset,
    probe_issue_unit_if.slave bus
);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e state, state_nxt;
    probe_req_t req;
    logic [N_CLIENTS-1:0] to_issue, pending, issued, pick_oh, c_src_oh;
    logic [SRC_W-1:0] pick_idx, lock_src;
    logic [BEAT_W-1:0] beat_cnt;
    logic dirty, had_t, err, locked;
    logic req_ready, b_valid, c_ready, wb_valid, resp_valid;
    logic req_fire, b_fire, c_fire;
    logic c_active, c_legal, c_stall, c_data, c_ack, c_drop, c_last;

    lowest_one_pick #(.N(N_CLIENTS), .W(SRC_W)) u_pick (
        .vec(to_issue),
        .onehot(pick_oh),
        .idx(pick_idx)
    );

    // Channel C classification: a message is either a data beat, a dataless ack,
    // an illegal message that is swallowed, or stalled behind another client's burst.
    always_comb begin
        c_src_oh = N_CLIENTS'(1) << bus.io_c_source;
        c_active = state == S_PROBE || state == S_COLLECT;
        c_legal = |(issued & pending & c_src_oh) && bus.io_c_address == req.addr &&
                  (bus.io_c_opcode == OP_PROBE_ACK || bus.io_c_opcode == OP_PROBE_ACK_DATA);
        c_stall = locked && bus.io_c_source != lock_src;
        // Once a burst is locked, beats from the owning client are not re-qualified.
        c_data = c_active && !c_stall && (locked || (c_legal && bus.io_c_opcode == OP_PROBE_ACK_DATA));
        c_ack = c_active && !locked && c_legal && bus.io_c_opcode == OP_PROBE_ACK;
        c_drop = c_active && !locked && !c_legal;
        c_last = c_data && beat_cnt == LAST_BEAT;
        c_ready = c_data ? bus.io_wb_ready : c_ack || c_drop;
        c_fire = bus.io_c_valid && c_ready;
        wb_valid = c_data && bus.io_c_valid;
    end

    always_comb begin
        state_nxt = state;
        req_ready = state == S_IDLE;
        b_valid = state == S_PROBE;
        resp_valid = state == S_RESP;
        req_fire = bus.io_req_valid && req_ready;
        b_fire = b_valid && bus.io_b_ready;
        case (state)
            S_IDLE: if (req_fire) state_nxt = bus.io_req_mask == '0 ? S_RESP : S_PROBE;
            S_PROBE: if (b_fire && (to_issue & ~pick_oh) == '0) state_nxt = S_COLLECT;
            S_COLLECT: if (pending == '0) state_nxt = S_RESP;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= S_IDLE;
        else state <= state_nxt;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            req <= '0;
            to_issue <= '0;
            pending <= '0;
            issued <= '0;
            dirty <= 1'b0;
            had_t <= 1'b0;
            err <= 1'b0;
            locked <= 1'b0;
            lock_src <= '0;
            beat_cnt <= '0;
        end else begin
            if (req_fire) begin
                req <= '{addr: bus.io_req_addr, param: bus.io_req_param};
                to_issue <= bus.io_req_mask;
                pending <= bus.io_req_mask;
                issued <= '0;
                dirty <= 1'b0;
                had_t <= 1'b0;
            end
            if (b_fire) begin
                to_issue <= to_issue & ~pick_oh;
                issued <= issued | pick_oh;
            end
            if (c_fire && c_drop) err <= 1'b1;
            if (c_fire && (c_ack || c_last)) pending <= pending & ~c_src_oh;
            if (c_fire && (c_ack || c_data) && reports_t(bus.io_c_param)) had_t <= 1'b1;
            if (c_fire && c_last) dirty <= 1'b1;
            if (c_fire && c_data) begin
                beat_cnt <= c_last ? '0 : beat_cnt + 1'b1;
                locked <= !c_last;
                lock_src <= bus.io_c_source;
            end
        end

    assign bus.io_req_ready = req_ready;
    assign bus.io_b_valid = b_valid;
    assign bus.io_b_opcode = b_valid ? OP_PROBE : 3'd0;
    assign bus.io_b_param = req.param;
    assign bus.io_b_source = pick_idx;
    assign bus.io_b_address = req.addr;
    assign bus.io_b_size = b_valid ? BLOCK_LG_SIZE : 4'd0;
    assign bus.io_c_ready = c_ready;
    assign bus.io_wb_valid = wb_valid;
    assign bus.io_wb_data = c_data ? bus.io_c_data : '0;
    assign bus.io_wb_beat = beat_cnt;
    assign bus.io_wb_last = wb_valid && c_last;
    assign bus.io_resp_valid = resp_valid;
    assign bus.io_resp_dirty = resp_valid && dirty;
    assign bus.io_resp_had_t = resp_valid && had_t;
    assign bus.io_err = err;
    assign bus.io_busy = state != S_IDLE;
endmodule

// File: tb/tb_probe_issue_unit.sv
// tb_probe_issue_unit: directed and randomized checks of probe_issue_unit against a transaction-level model
module tb_probe_issue_unit;
    import probe_issue_unit_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    bit err_exp = 1'b0;

    probe_issue_unit_if bus();
    probe_issue_unit dut (.clock(clock), .reset(reset), .bus(bus.slave));

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_t(input int p);
        return p == 0 || p == 1 || p == 3;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.io_req_valid = 1'b0;
        bus.io_req_addr = '0;
        bus.io_req_param = '0;
        bus.io_req_mask = '0;
        bus.io_b_ready = 1'b0;
        bus.io_c_valid = 1'b0;
        bus.io_c_opcode = '0;
        bus.io_c_param = '0;
        bus.io_c_source = '0;
        bus.io_c_address = '0;
        bus.io_c_data = '0;
        bus.io_wb_ready = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", bus.io_req_ready, 1);
        check("rst_b_valid", bus.io_b_valid, 0);
        check("rst_b_opcode", bus.io_b_opcode, 0);
        check("rst_b_param", bus.io_b_param, 0);
        check("rst_b_source", bus.io_b_source, 0);
        check("rst_b_address", bus.io_b_address, 0);
        check("rst_b_size", bus.io_b_size, 0);
        check("rst_c_ready", bus.io_c_ready, 0);
        check("rst_wb_valid", bus.io_wb_valid, 0);
        check("rst_wb_data", bus.io_wb_data, 0);
        check("rst_wb_beat", bus.io_wb_beat, 0);
        check("rst_wb_last", bus.io_wb_last, 0);
        check("rst_resp_valid", bus.io_resp_valid, 0);
        check("rst_resp_dirty", bus.io_resp_dirty, 0);
        check("rst_resp_had_t", bus.io_resp_had_t, 0);
        check("rst_err", bus.io_err, 0);
        check("rst_busy", bus.io_busy, 0);
    endtask

    // Issues the request and checks that Probes go out in ascending client order.
    task automatic send_req(input logic [N_CLIENTS-1:0] mask, input logic [1:0] param,
                            input logic [ADDR_W-1:0] addr, input bit rand_b);
        int order[$];
        for (int i = 0; i < N_CLIENTS; i++) if (mask[i]) order.push_back(i);
        bus.io_req_valid = 1'b1;
        bus.io_req_addr = addr;
        bus.io_req_param = param;
        bus.io_req_mask = mask;
        #1;
        check("req_ready", bus.io_req_ready, 1);
        step();
        bus.io_req_valid = 1'b0;
        if (mask == '0) begin
            #1;
            check("mask0_b_valid", bus.io_b_valid, 0);
            check("mask0_resp_valid", bus.io_resp_valid, 1);
            check("mask0_resp_dirty", bus.io_resp_dirty, 0);
            check("mask0_resp_had_t", bus.io_resp_had_t, 0);
            step();
            #1;
            check("mask0_resp_pulse", bus.io_resp_valid, 0);
            check("mask0_req_ready", bus.io_req_ready, 1);
            return;
        end
        foreach (order[k]) begin
            int n = 0;
            do begin
                if (n > 0) step();
                bus.io_b_ready = (rand_b && n < 3) ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                check("b_valid", bus.io_b_valid, 1);
                check("b_source", bus.io_b_source, order[k]);
                check("b_opcode", bus.io_b_opcode, 6);
                check("b_param", bus.io_b_param, param);
                check("b_address", bus.io_b_address, addr);
                check("b_size", bus.io_b_size, 6);
                n++;
            end while (!bus.io_b_ready);
            step();
        end
        bus.io_b_ready = 1'b0;
        #1;
        check("b_done", bus.io_b_valid, 0);
        check("collect_busy", bus.io_busy, 1);
    endtask

    task automatic send_ack(input logic [SRC_W-1:0] src, input logic [2:0] prm, input logic [ADDR_W-1:0] addr);
        bus.io_c_valid = 1'b1;
        bus.io_c_opcode = OP_PROBE_ACK;
        bus.io_c_source = src;
        bus.io_c_param = prm;
        bus.io_c_address = addr;
        #1;
        check("ack_c_ready", bus.io_c_ready, 1);
        check("ack_wb_valid", bus.io_wb_valid, 0);
        step();
        bus.io_c_valid = 1'b0;
    endtask

    // Streams one ProbeAckData burst. stall_at presents another client for a cycle
    // before that beat; rst_at asserts reset while that beat is on the bus.
    task automatic send_data(input logic [SRC_W-1:0] src, input logic [2:0] prm, input logic [ADDR_W-1:0] addr,
                             input bit rand_wb, input int stall_at, input int rst_at);
        for (int beat = 0; beat < BEATS; beat++) begin
            logic [DATA_W-1:0] d;
            int n;
            d = {$urandom, $urandom};
            n = 0;
            if (beat == stall_at) begin
                bus.io_c_valid = 1'b1;
                bus.io_c_opcode = OP_PROBE_ACK;
                bus.io_c_source = src ^ SRC_W'(1);
                bus.io_c_param = RPT_N_TO_N;
                bus.io_c_address = addr;
                bus.io_wb_ready = 1'b1;
                #1;
                check("stall_c_ready", bus.io_c_ready, 0);
                check("stall_wb_valid", bus.io_wb_valid, 0);
                step();
            end
            bus.io_c_valid = 1'b1;
            bus.io_c_opcode = OP_PROBE_ACK_DATA;
            bus.io_c_source = src;
            bus.io_c_param = prm;
            bus.io_c_address = addr;
            bus.io_c_data = d;
            if (beat == rst_at) begin
                bus.io_wb_ready = 1'b1;
                reset = 1'b0;
                err_exp = 1'b0;
                #1;
                check_reset_outputs();
                return;
            end
            do begin
                if (n > 0) step();
                bus.io_wb_ready = (rand_wb && n < 3) ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                check("wb_valid", bus.io_wb_valid, 1);
                check("wb_data", bus.io_wb_data, d);
                check("wb_beat", bus.io_wb_beat, beat);
                check("wb_last", bus.io_wb_last, beat == BEATS - 1);
                check("data_c_ready", bus.io_c_ready, bus.io_wb_ready);
                n++;
            end while (!bus.io_wb_ready);
            step();
        end
        bus.io_c_valid = 1'b0;
        bus.io_wb_ready = 1'b0;
    endtask

    // Illegal C message: must be accepted, dropped, flag err and leave pending alone.
    task automatic send_bad(input logic [SRC_W-1:0] src, input logic [2:0] op, input logic [ADDR_W-1:0] addr);
        bus.io_c_valid = 1'b1;
        bus.io_c_opcode = op;
        bus.io_c_source = src;
        bus.io_c_param = 3'($urandom_range(0, 5));
        bus.io_c_address = addr;
        bus.io_c_data = {$urandom, $urandom};
        bus.io_wb_ready = 1'($urandom_range(0, 1));
        #1;
        check("bad_c_ready", bus.io_c_ready, 1);
        check("bad_wb_valid", bus.io_wb_valid, 0);
        step();
        bus.io_c_valid = 1'b0;
        bus.io_wb_ready = 1'b0;
        err_exp = 1'b1;
        #1;
        check("bad_err", bus.io_err, 1);
        step();
        check("bad_no_resp", bus.io_resp_valid, 0);
        check("bad_busy", bus.io_busy, 1);
    endtask

    task automatic finish_resp(input bit d, input bit h);
        #1;
        check("resp_early", bus.io_resp_valid, 0);
        check("resp_busy", bus.io_busy, 1);
        step();
        check("resp_valid", bus.io_resp_valid, 1);
        check("resp_dirty", bus.io_resp_dirty, d);
        check("resp_had_t", bus.io_resp_had_t, h);
        step();
        check("resp_pulse", bus.io_resp_valid, 0);
        check("resp_idle", bus.io_busy, 0);
        check("resp_req_ready", bus.io_req_ready, 1);
        check("err_sticky", bus.io_err, err_exp);
    endtask

    task automatic random_txn();
        logic [N_CLIENTS-1:0] mask;
        logic [ADDR_W-1:0] addr;
        bit d, h;
        bit [N_CLIENTS-1:0] acked;
        int order[$];
        mask = N_CLIENTS'($urandom_range(0, (1 << N_CLIENTS) - 1));
        addr = $urandom & ~32'h3f;
        d = 1'b0;
        h = 1'b0;
        acked = '0;
        for (int i = 0; i < N_CLIENTS; i++) if (mask[i]) order.push_back(i);
        if (order.size() == 2 && $urandom_range(0, 1) == 1) order = '{order[1], order[0]};
        send_req(mask, 2'($urandom_range(0, 2)), addr, 1'b1);
        if (mask == '0) return;
        foreach (order[k]) begin
            logic [SRC_W-1:0] src;
            logic [2:0] prm;
            src = SRC_W'(order[k]);
            prm = 3'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) begin
                logic [SRC_W-1:0] bsrc;
                logic [ADDR_W-1:0] baddr;
                bsrc = SRC_W'($urandom_range(0, N_CLIENTS - 1));
                baddr = $urandom_range(0, 1) ? addr : addr ^ 32'h40;
                if (mask[bsrc] && !acked[bsrc] && baddr == addr) baddr = addr ^ 32'h40;
                send_bad(bsrc, $urandom_range(0, 1) ? OP_PROBE_ACK : OP_PROBE_ACK_DATA, baddr);
            end
            if ($urandom_range(0, 1) == 1) begin
                send_data(src, prm, addr, 1'b1, -1, -1);
                d = 1'b1;
            end else send_ack(src, prm, addr);
            h = h | is_t(prm);
            acked[src] = 1'b1;
        end
        finish_resp(d, h);
    endtask

    initial begin
        idle_inputs();
        #1;
        check_reset_outputs();
        step();
        step();
        reset = 1'b1;
        step();
        // Two clients, dataless NtoN acks.
        send_req(2'b11, CAP_TO_N, 32'h0000_1000, 1'b0);
        send_ack(1'b0, RPT_N_TO_N, 32'h0000_1000);
        send_ack(1'b1, RPT_N_TO_N, 32'h0000_1000);
        finish_resp(1'b0, 1'b0);
        // Single client returns dirty data with a toggling writeback ready.
        send_req(2'b01, CAP_TO_N, 32'h0000_2040, 1'b0);
        send_data(1'b0, RPT_T_TO_N, 32'h0000_2040, 1'b1, -1, -1);
        finish_resp(1'b1, 1'b1);
        // Empty mask completes without any Probe.
        send_req(2'b00, CAP_TO_B, 32'h0000_3000, 1'b0);
        // Client 1 ack arrives while client 0 is mid-burst.
        send_req(2'b11, CAP_TO_B, 32'h0000_4080, 1'b1);
        send_data(1'b0, RPT_B_TO_B, 32'h0000_4080, 1'b1, 3, -1);
        send_ack(1'b1, RPT_N_TO_N, 32'h0000_4080);
        finish_resp(1'b1, 1'b0);
        // Wrong address and un-probed source are dropped.
        send_req(2'b01, CAP_TO_T, 32'h0000_5000, 1'b0);
        send_bad(1'b0, OP_PROBE_ACK, 32'h0000_5040);
        send_bad(1'b1, OP_PROBE_ACK, 32'h0000_5000);
        send_ack(1'b0, RPT_T_TO_T, 32'h0000_5000);
        finish_resp(1'b0, 1'b1);
        for (int t = 0; t < 40; t++) random_txn();
        // Reset in the middle of a burst, then a fresh burst restarts at beat 0.
        send_req(2'b01, CAP_TO_B, 32'h0000_6000, 1'b0);
        send_data(1'b0, RPT_T_TO_B, 32'h0000_6000, 1'b0, -1, 3);
        idle_inputs();
        step();
        reset = 1'b1;
        step();
        send_req(2'b01, CAP_TO_N, 32'h0000_7000, 1'b0);
        send_data(1'b0, RPT_B_TO_N, 32'h0000_7000, 1'b1, -1, -1);
        finish_resp(1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
